// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART TX arbiter.
// Used by the round-robin picker and the arbiter top.
package uart_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      WAIT_DONE,
      GAP
   } arb_state_e;

   localparam int DEFAULT_CLKS_PER_BIT = 217;

   // Twelve bit times: one full frame plus margin.
   function automatic int default_timeout(input int clks_per_bit);
      return 12 * clks_per_bit;
   endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin picker: rotate the request vector, pick the lowest set bit,
// then rotate the one-hot result back to requester positions.
module uart_rr_pick
   import uart_arb_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int IW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IW-1:0]      i_last,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic               o_vld
);

   logic [NUM_REQ-1:0] rot;
   logic [NUM_REQ-1:0] pe;

   function automatic logic [IW-1:0] wrap(input int v);
      return IW'(v % NUM_REQ);
   endfunction

   always_comb begin
      rot   = '0;
      pe    = '0;
      o_gnt = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         rot[i] = i_req[wrap(int'(i_last) + 1 + i)];
      end
      // Walking downward leaves the lowest set bit as the winner.
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (rot[i]) pe = NUM_REQ'(1) << i;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         o_gnt[wrap(int'(i_last) + 1 + i)] = pe[i];
      end
   end

   assign o_vld = |i_req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART_TX serializer among NUM_REQ byte producers,
// round-robin, with a done/timeout wait and an idle guard gap.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int GAP_CLKS     = 217,
   parameter int TIMEOUT_CLKS = default_timeout(DEFAULT_CLKS_PER_BIT)
) (
   input  logic                 i_Clk,
   input  logic                 i_Reset,
   input  logic [NUM_REQ-1:0]   i_Req,
   input  logic [8*NUM_REQ-1:0] i_Req_Byte,
   output logic [NUM_REQ-1:0]   o_Grant,
   output logic [NUM_REQ-1:0]   o_Ack,
   output logic                 o_Timeout,
   output logic                 o_TX_DV,
   output logic [7:0]           o_TX_Byte,
   input  logic                 i_TX_Active,
   input  logic                 i_TX_Done,
   output logic                 o_Busy
);

   localparam int IW      = $clog2(NUM_REQ);
   localparam int CNT_TOP = (GAP_CLKS > TIMEOUT_CLKS) ?
                            GAP_CLKS : TIMEOUT_CLKS;
   localparam int CW      = $clog2(CNT_TOP + 1);

   localparam logic [CW-1:0] TMO_LAST =
      CW'(TIMEOUT_CLKS - 1);
   localparam logic [CW-1:0] GAP_LAST =
      CW'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);
   localparam logic [CW-1:0] CNT_SAT = '1;

   arb_state_e         state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [IW-1:0]      last_q, last_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [NUM_REQ-1:0] ack_q, ack_d;
   logic               tmo_q, tmo_d;
   logic               dv_q, dv_d;
   logic [7:0]         byte_q, byte_d;
   logic               busy_q, busy_d;

   logic [NUM_REQ-1:0] pick_gnt;
   logic               pick_vld;
   logic [7:0]         pick_byte;
   logic [IW-1:0]      grant_idx;

   function automatic logic [CW-1:0] sat_inc(
      input logic [CW-1:0] v
   );
      return (v == CNT_SAT) ? v : v + CW'(1);
   endfunction

   uart_rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .i_req  (i_Req),
      .i_last (last_q),
      .o_gnt  (pick_gnt),
      .o_vld  (pick_vld)
   );

   always_comb begin
      pick_byte = '0;
      grant_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (pick_gnt[k]) pick_byte = i_Req_Byte[8*k +: 8];
         if (grant_q[k])  grant_idx = IW'(k);
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      grant_d = grant_q;
      ack_d   = '0;
      tmo_d   = 1'b0;
      dv_d    = 1'b0;
      byte_d  = byte_q;
      unique case (state_q)
         IDLE: begin
            if (pick_vld && !i_TX_Active) begin
               grant_d = pick_gnt;
               byte_d  = pick_byte;
               dv_d    = 1'b1;
               state_d = LOAD;
            end
         end
         LOAD: begin
            cnt_d   = '0;
            state_d = WAIT_DONE;
         end
         WAIT_DONE: begin
            // A done on the expiry cycle still counts as normal completion.
            if (i_TX_Done || cnt_q == TMO_LAST) begin
               ack_d   = grant_q;
               tmo_d   = !i_TX_Done;
               last_d  = grant_idx;
               grant_d = '0;
               cnt_d   = '0;
               state_d = (GAP_CLKS == 0) ? IDLE : GAP;
            end else begin
               cnt_d = sat_inc(cnt_q);
            end
         end
         GAP: begin
            if (cnt_q >= GAP_LAST) begin
               state_d = IDLE;
            end else begin
               cnt_d = sat_inc(cnt_q);
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge i_Clk or negedge i_Reset) begin
      if (!i_Reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         last_q  <= IW'(NUM_REQ - 1);
         grant_q <= '0;
         ack_q   <= '0;
         tmo_q   <= 1'b0;
         dv_q    <= 1'b0;
         byte_q  <= 8'h00;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         grant_q <= grant_d;
         ack_q   <= ack_d;
         tmo_q   <= tmo_d;
         dv_q    <= dv_d;
         byte_q  <= byte_d;
         busy_q  <= busy_d;
      end
   end

   assign o_Grant   = grant_q;
   assign o_Ack     = ack_q;
   assign o_Timeout = tmo_q;
   assign o_TX_DV   = dv_q;
   assign o_TX_Byte = byte_q;
   assign o_Busy    = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: table vectors, corner sequences and
// randomized traffic against a timestamp-based reference model.
module tb_uart_tx_arbiter;

   localparam int N = 4;
   localparam int G = 5;
   localparam int T = 40;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req = '0;
   logic [8*N-1:0] bytes = '0;
   logic           active = 1'b0;
   logic           done = 1'b0;
   logic [N-1:0]   grant, ack;
   logic           tmo, dv, busy;
   logic [7:0]     txb;

   int nvec = 0;
   int nerr = 0;

   uart_tx_arbiter #(
      .NUM_REQ      (N),
      .GAP_CLKS     (G),
      .TIMEOUT_CLKS (T)
   ) dut (
      .i_Clk       (clk),
      .i_Reset     (rst_n),
      .i_Req       (req),
      .i_Req_Byte  (bytes),
      .o_Grant     (grant),
      .o_Ack       (ack),
      .o_Timeout   (tmo),
      .o_TX_DV     (dv),
      .o_TX_Byte   (txb),
      .i_TX_Active (active),
      .i_TX_Done   (done),
      .o_Busy      (busy)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act,
                        input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   // Serializer stand-in: busy for a frame after DV, then a done pulse.
   int ser_len   = 8;
   int ser_cnt   = 0;
   bit ser_stuck = 0;
   bit ser_spur  = 0;
   bit ser_rand  = 0;

   initial forever begin
      @(posedge clk);
      #1;
      done = 1'b0;
      if (ser_spur && $urandom_range(39) == 0) done = 1'b1;
      if (dv === 1'b1) begin
         active  = 1'b1;
         ser_cnt = ser_rand ? int'($urandom_range(48, 2)) : ser_len;
      end else if (ser_cnt > 0) begin
         ser_cnt--;
         if (ser_cnt == 0) begin
            active = 1'b0;
            if (!ser_stuck) done = 1'b1;
         end
      end
   end

   // Reference model in edge timestamps: a transfer starts at edge a,
   // completes on a done seen from edge a+2 on, or at edge a+1+T.
   int k, a, wi, last, next_arb, busy_end;
   bit in_x;
   logic [N-1:0] e_grant, e_ack;
   logic         e_tmo, e_dv, e_busy;
   logic [7:0]   e_byte;

   function automatic int pick(input logic [N-1:0] r, input int l);
      for (int i = 1; i <= N; i++) begin
         if (r[(l + i) % N]) return (l + i) % N;
      end
      return 0;
   endfunction

   task automatic m_reset();
      k = 0; a = 0; wi = 0; in_x = 0;
      last = N - 1; next_arb = 0; busy_end = 0;
      e_grant = '0; e_ack = '0; e_tmo = 0;
      e_dv = 0; e_byte = '0; e_busy = 0;
   endtask

   task automatic m_step();
      bit fin;
      k++;
      e_dv = 0; e_ack = '0; e_tmo = 0;
      if (in_x) begin
         fin = (k >= a + 2) && (done === 1'b1);
         if (fin || k == a + 1 + T) begin
            e_ack = e_grant; e_tmo = !fin; last = wi;
            e_grant = '0; in_x = 0;
            next_arb = k + G + 1; busy_end = k + G;
         end
      end else if (k >= next_arb && |req && !active) begin
         wi = pick(req, last);
         e_grant = N'(1) << wi;
         e_byte = bytes[8*wi +: 8];
         e_dv = 1; in_x = 1; a = k;
      end
      e_busy = in_x || (k < busy_end);
   endtask

   initial begin
      m_reset();
      forever begin
         @(posedge clk);
         if (!rst_n) m_reset();
         else m_step();
      end
   end

   initial forever begin
      @(negedge clk);
      if (!rst_n) m_reset();
      check("model", {grant, ack, tmo, dv, txb, busy},
            {e_grant, e_ack, e_tmo, e_dv, e_byte, e_busy});
   end

   task automatic wait_dv(output int n);
      n = 0;
      do begin @(posedge clk); #1; n++; end
      while (dv !== 1'b1 && n < 200);
      check("dv_seen", dv, 1);
   endtask

   task automatic wait_ack(output int n);
      n = 0;
      do begin @(posedge clk); #1; n++; end
      while (!(|ack) && n < 200);
      check("ack_seen", |ack, 1);
   endtask

   typedef struct packed {
      logic [N-1:0]   req;
      logic [8*N-1:0] bytes;
      logic [N-1:0]   gnt;
      logic [7:0]     byt;
   } vec_t;

   vec_t tbl[10];
   int   exp_rr[5] = '{1, 2, 3, 0, 1};

   initial begin
      int n, seen;
      logic [N-1:0] oh;
      tbl[0] = '{4'b0001, 32'h433221A5, 4'b0001, 8'hA5};
      tbl[1] = '{4'b1111, 32'h43322110, 4'b0010, 8'h21};
      tbl[2] = '{4'b0101, 32'h43322110, 4'b0100, 8'h32};
      tbl[3] = '{4'b0101, 32'h43322110, 4'b0001, 8'h10};
      tbl[4] = '{4'b1000, 32'h43322110, 4'b1000, 8'h43};
      tbl[5] = '{4'b0110, 32'h43322110, 4'b0010, 8'h21};
      tbl[6] = '{4'b0011, 32'h43322110, 4'b0001, 8'h10};
      tbl[7] = '{4'b1100, 32'h43322110, 4'b0100, 8'h32};
      tbl[8] = '{4'b1010, 32'h43322110, 4'b1000, 8'h43};
      tbl[9] = '{4'b1111, 32'h43322110, 4'b0001, 8'h10};

      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_outputs", {grant, ack, tmo, dv, txb, busy}, '0);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         req = tbl[i].req;
         bytes = tbl[i].bytes;
         wait_dv(n);
         check("tbl_grant", grant, tbl[i].gnt);
         check("tbl_byte", txb, tbl[i].byt);
         bytes = ~bytes;
         wait_ack(n);
         check("tbl_ack", ack, tbl[i].gnt);
         check("tbl_tmo", tmo, 0);
         check("tbl_hold", txb, tbl[i].byt);
         req = '0;
      end

      req = 4'b1111;
      bytes = 32'h43322110;
      wait_dv(n);
      for (int i = 0; i < 5; i++) begin
         oh = 4'b0001 << exp_rr[i];
         check("rr_grant", grant, oh);
         check("rr_byte", txb, bytes[8*exp_rr[i] +: 8]);
         if (i < 4) begin
            wait_dv(n);
            check("rr_spacing", n, ser_len + G + 2);
         end
      end
      req = '0;
      wait_ack(n);

      req = 4'b0100;
      wait_dv(n);
      check("cont_first", grant, 4'b0100);
      req = 4'b0110;
      wait_ack(n);
      wait_dv(n);
      check("cont_next", grant, 4'b0010);
      req = '0;
      wait_ack(n);

      req = 4'b0001;
      wait_dv(n);
      check("drop_grant", grant, 4'b0001);
      repeat (2) @(posedge clk);
      #1 req = '0;
      wait_ack(n);
      check("drop_ack", ack, 4'b0001);
      seen = 0;
      repeat (30) begin
         @(posedge clk); #1;
         if (dv === 1'b1) seen++;
      end
      check("drop_noregrant", seen, 0);

      ser_stuck = 1;
      ser_len = 60;
      req = 4'b0010;
      wait_dv(n);
      req = '0;
      wait_ack(n);
      check("tmo_latency", n, T + 1);
      check("tmo_flag", tmo, 1);
      check("tmo_ack", ack, 4'b0010);
      repeat (40) @(posedge clk);
      #1;
      ser_stuck = 0;
      ser_len = 8;
      check("tmo_idle", busy, 0);

      req = 4'b0100;
      wait_dv(n);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("rst_mid", {grant, ack, tmo, dv, txb, busy}, '0);
      req = 4'b1111;
      @(posedge clk);
      #1 rst_n = 1'b1;
      wait_dv(n);
      check("rst_first", grant, 4'b0001);
      req = '0;
      wait_ack(n);

      ser_rand = 1;
      ser_spur = 1;
      repeat (3000) begin
         @(posedge clk);
         #1;
         for (int r = 0; r < N; r++) begin
            if (ack[r]) begin
               if ($urandom_range(1) == 0) req[r] = 1'b0;
               bytes[8*r +: 8] = 8'($urandom);
            end else if (!req[r]) begin
               if ($urandom_range(7) == 0) begin
                  req[r] = 1'b1;
                  bytes[8*r +: 8] = 8'($urandom);
               end
            end else begin
               if ($urandom_range(63) == 0) req[r] = 1'b0;
               if ($urandom_range(31) == 0)
                  bytes[8*r +: 8] = 8'($urandom);
            end
         end
      end
      ser_spur = 0;
      req = '0;
      repeat (120) @(posedge clk);
      #1;
      check("final_idle", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
